// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the MEM-stage data-memory responder: FSM state
// encodings and the request size / direction codes.
package data_mem_responder_pkg;

    // Responder FSM state
    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_BUSY = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // Request size (Size port)
    localparam logic SIZE_BYTE = 1'b0;
    localparam logic SIZE_WORD = 1'b1;

    // Request direction (RW port)
    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/dmem_byte_array.sv
// Byte-addressed, big-endian data storage. Lane k addresses i_addr+k
// (modulo DEPTH); lane 0 carries the most significant byte of the word.
// Contents have no reset so a preload survives the responder reset.
module dmem_byte_array #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 256
) (
    input  logic              i_clk,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [3:0]        i_we,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_rdata
);

    logic [7:0]        r_mem [DEPTH];
    logic [ADDR_W-1:0] w_lane_addr [4];

    // Per-lane addresses; ADDR_W-bit addition gives the wrap for free
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_lane_addr[k] = i_addr + ADDR_W'(k);
        end
    end

    // Four-byte big-endian read port
    always_comb begin
        o_rdata = {r_mem[w_lane_addr[0]], r_mem[w_lane_addr[1]],
                   r_mem[w_lane_addr[2]], r_mem[w_lane_addr[3]]};
    end

    // Lane-enabled write port
    always_ff @(posedge i_clk) begin
        for (int k = 0; k < 4; k++) begin
            if (i_we[k]) begin
                r_mem[w_lane_addr[k]] <= i_wdata[31-8*k -: 8];
            end
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder for the MEM stage. Accepts one byte/word request
// in IDLE, waits WAIT cycles, commits the access on the edge entering DONE
// and pulses rdy for one cycle.
// Build option DMEM_MISALIGN_TRAP_EN: misaligned word requests complete
// with err=1 and no side effects; otherwise word addresses are silently
// aligned and err stays 0.
module data_mem_responder #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned WAIT   = 1
) (
    input  logic              clk,
    input  logic              R,
    input  logic              E,
    input  logic              RW,
    input  logic              Size,
    input  logic [ADDR_W-1:0] A,
    input  logic [31:0]       DI,
    output logic [31:0]       DO,
    output logic              rdy,
    output logic              err
);

    import data_mem_responder_pkg::*;

    localparam logic [3:0] WAIT_CNT = 4'(WAIT);
    localparam logic       NO_WAIT  = (WAIT == 0);

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic              r_rw;
    logic              r_size;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_di;
    logic [31:0]       r_do;
    logic              r_rdy;
    logic              r_err;

    logic              w_accept;
    logic              w_commit;
    logic              w_rw;
    logic              w_size;
    logic [ADDR_W-1:0] w_addr_raw;
    logic [ADDR_W-1:0] w_addr;
    logic [31:0]       w_di;
    logic              w_trap;
    logic [3:0]        w_we;
    logic [31:0]       w_wdata;
    logic [31:0]       w_rdata;

    // Effective request: with WAIT=0 the commit shares the capture edge, so
    // the live inputs are used in IDLE and the captured copy afterwards.
    always_comb begin
        w_accept   = (r_state == ST_IDLE) && E;
        w_commit   = !R && ((w_accept && NO_WAIT) ||
                            ((r_state == ST_BUSY) && (r_cnt == 4'd1)));
        w_rw       = (r_state == ST_IDLE) ? RW   : r_rw;
        w_size     = (r_state == ST_IDLE) ? Size : r_size;
        w_addr_raw = (r_state == ST_IDLE) ? A    : r_addr;
        w_di       = (r_state == ST_IDLE) ? DI   : r_di;
`ifdef DMEM_MISALIGN_TRAP_EN
        w_trap = (w_size == SIZE_WORD) && (w_addr_raw[1:0] != 2'b00);
        w_addr = w_addr_raw;
`else
        w_trap = 1'b0;
        w_addr = (w_size == SIZE_WORD) ? {w_addr_raw[ADDR_W-1:2], 2'b00} : w_addr_raw;
`endif
        w_we    = 4'b0000;
        if (w_commit && (w_rw == RW_WRITE) && !w_trap) begin
            w_we = (w_size == SIZE_WORD) ? 4'b1111 : 4'b0001;
        end
        w_wdata = (w_size == SIZE_WORD) ? w_di : {w_di[7:0], 24'h000000};
    end

    dmem_byte_array #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .i_clk   (clk),
        .i_addr  (w_addr),
        .i_we    (w_we),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata)
    );

    // Request FSM, wait counter and request capture
    always_ff @(posedge clk) begin
        if (R) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_rw    <= RW_READ;
            r_size  <= SIZE_BYTE;
            r_addr  <= '0;
            r_di    <= 32'h0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (E) begin
                        r_rw    <= RW;
                        r_size  <= Size;
                        r_addr  <= A;
                        r_di    <= DI;
                        r_cnt   <= WAIT_CNT;
                        r_state <= NO_WAIT ? ST_DONE : ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Completion pulse, error flag and read-data register
    always_ff @(posedge clk) begin
        if (R) begin
            r_do  <= 32'h0;
            r_rdy <= 1'b0;
            r_err <= 1'b0;
        end else begin
            r_rdy <= w_commit;
            r_err <= w_commit && w_trap;
            if (w_commit && (w_rw == RW_READ) && !w_trap) begin
                r_do <= (w_size == SIZE_WORD) ? w_rdata : {24'h000000, w_rdata[31:24]};
            end
        end
    end

    assign DO  = r_do;
    assign rdy = r_rdy;
    assign err = r_err;

endmodule
